sel_modo_de_jogo: RTL and testbench
===================================

// Module: sel_modo_de_jogo
// PURPOSE
// - Game-mode selector: the encoder side of the mode path. Turns two raw pushbuttons into the 2-bit mode code {A,B}.
// - {A,B} drives the game-mode 7-segment decoder and the game logic.
// - Player steps through the 4 modes with "next", locks one with "confirm"; the game logic unlocks it at game end.
// - Also emits a blink enable so the display flashes while a mode is not yet confirmed.
// PARAMETERS
// - DEB_CYCLES    500000    consecutive stable cycles for a debounced level change (10 ms @ 50 MHz)
// - BLINK_CYCLES  12500000  cycles per piscar half-period (0.25 s @ 50 MHz)
// PORTS
// - clk         in   1  system clock, all state on rising edge
// - rst_n       in   1  asynchronous active-low reset
// - btn_prox_n  in   1  raw "next mode" pushbutton, active-low, asynchronous to clk
// - btn_conf_n  in   1  raw "confirm" pushbutton, active-low, asynchronous to clk
// - fim_jogo    in   1  game over from game logic, synchronous to clk, level; unlocks selection
// - A           out  1  mode code MSB (to decoder input A)
// - B           out  1  mode code LSB (to decoder input B)
// - travado     out  1  1 = mode confirmed/locked
// - piscar      out  1  display enable; toggles while selecting
// BEHAVIOUR
// - Clock/reset: one clock, clk. Reset is asynchronous and active-low (rst_n); polarity and synchronicity are fixed.
// - Reset state (rst_n=0, asynchronous):
//   - {A,B}=2'b00, travado=0, piscar=1, FSM=SELECAO.
//   - All counters 0; debounced button levels = released.
//   - Synchronizer flops = released (1).
// - Input path, per button:
//   - 2-flop synchronizer, then debouncer.
//   - Debounced level follows the synced level only after the synced level has differed from it for DEB_CYCLES consecutive cycles.
//   - Any cycle of agreement clears the counter.
//   - One-cycle pulse (prox_p / conf_p) on the debounced released->pressed transition only.
//   - Button held indefinitely: exactly one pulse.
//   - Release is debounced identically.
// - Latency: btn low first sampled at edge t -> pulse high in cycle t+2+DEB_CYCLES -> {A,B}/travado update at the next edge.
// - FSM SELECAO (travado=0):
//   - prox_p: {A,B} <= {A,B}+1 mod 4 (wraps 11 -> 00).
//   - conf_p: -> CONFIRMADO, {A,B} unchanged.
//   - prox_p and conf_p in the same cycle: confirm wins, no increment.
//   - fim_jogo is ignored.
// - FSM CONFIRMADO (travado=1):
//   - prox_p and conf_p are ignored; {A,B} frozen.
//   - fim_jogo=1: -> SELECAO next edge, {A,B} retained.
// - piscar:
//   - SELECAO: blink counter counts 0..BLINK_CYCLES-1; piscar toggles on wrap.
//   - prox_p: counter cleared and piscar forced 1, so the new mode shows immediately.
//   - CONFIRMADO: piscar=1 constant, counter held at 0.
// - rst_n low mid-debounce or mid-game:
//   - Immediate return to reset state.
//   - A press already in progress produces no pulse unless it stays pressed DEB_CYCLES after the synchronizers refill.
// - Widths: counters $clog2(param)+1 bits; no arithmetic overflow beyond mod-4 mode wrap.
// STRUCTURE
// - Shared include modo_de_jogo_defs.vh:
//   - mode codes MODO_0..MODO_3 (2'b00..2'b11), shared with the decoder.
//   - FSM encodings SELECAO=1'b0, CONFIRMADO=1'b1.
// - Sub-module debounce_botao, instantiated twice:
//   - ports clk, rst_n, btn_n, pulso; parameter DEB_CYCLES.
//   - contains the synchronizer, debounce counter and edge detector.
// - Top: mode register, FSM, blink counter.
// TESTING (sim with DEB_CYCLES=4, BLINK_CYCLES=8)
// - Reset: rst_n=0 -> {A,B}=00, travado=0, piscar=1. Release, then 20 idle cycles -> {A,B} stays 00, piscar toggles every 8 cycles.
// - Clean presses: 4 presses of btn_prox_n (12 cycles low, 12 high) -> {A,B}=01,10,11,00. Each change lands exactly 7 edges after the press is first sampled.
// - Bounce: btn_prox_n low 3 cycles, high 1, low 3 -> no change. Then held low 50 cycles -> exactly one increment.
// - Lock: conf press -> travado=1, piscar=1. 3 prox presses -> {A,B} unchanged. fim_jogo=1 one cycle -> travado=0, mode retained, blinking resumes.
// - Simultaneous: prox and conf pressed on the same cycle with {A,B}=10 -> travado=1, {A,B}=10.
// - Reset mid-op: rst_n=0 while prox is mid-debounce and while in CONFIRMADO -> outputs at reset values asynchronously. No pulse after release.

Source files
------------

// File: rtl/sel_modo_de_jogo_pkg.sv
// Shared definitions for the game-mode selector: mode codes, FSM states and
// the mode-advance helper used by the selector top.
package sel_modo_de_jogo_pkg;

  localparam logic [1:0] MODO_0 = 2'b00;
  localparam logic [1:0] MODO_1 = 2'b01;
  localparam logic [1:0] MODO_2 = 2'b10;
  localparam logic [1:0] MODO_3 = 2'b11;

  typedef enum logic {
    SELECAO    = 1'b0,
    CONFIRMADO = 1'b1
  } estado_t;

  // Next mode in the cyclic order MODO_0 -> MODO_1 -> MODO_2 -> MODO_3 -> MODO_0
  function automatic logic [1:0] proximo_modo(input logic [1:0] modo);
    logic [1:0] r;
    case (modo)
      MODO_0:  r = MODO_1;
      MODO_1:  r = MODO_2;
      MODO_2:  r = MODO_3;
      MODO_3:  r = MODO_0;
      default: r = MODO_0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sel_modo_de_jogo_debounce_botao.sv
// Pushbutton front end: 2-flop synchronizer, stable-level debouncer and a
// one-cycle pulse on the debounced released->pressed transition.
module debounce_botao #(
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic pulso
);

  localparam int unsigned CW = $clog2(DEB_CYCLES) + 1;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_deb;
  logic          r_deb_d;
  logic [CW-1:0] r_cnt;
  logic          r_pulso;

  // Synchronizer; released (1) out of reset so no spurious press is seen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= btn_n;
      r_sync2 <= r_sync1;
    end
  end

  // Debounced level flips only after DEB_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_deb <= 1'b1;
      r_cnt <= '0;
    end else if (r_sync2 == r_deb) begin
      r_cnt <= '0;
    end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
      r_deb <= r_sync2;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_deb_d <= 1'b1;
      r_pulso <= 1'b0;
    end else begin
      r_deb_d <= r_deb;
      r_pulso <= r_deb_d & ~r_deb;
    end
  end

  assign pulso = r_pulso;

endmodule

// File: rtl/sel_modo_de_jogo.sv
// Game-mode selector: steps the 2-bit mode code {A,B} with "next", locks it
// with "confirm", unlocks on fim_jogo, and drives the display blink enable.
module sel_modo_de_jogo
  import sel_modo_de_jogo_pkg::*;
#(
  parameter int unsigned DEB_CYCLES   = 500000,
  parameter int unsigned BLINK_CYCLES = 12500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_prox_n,
  input  logic btn_conf_n,
  input  logic fim_jogo,
  output logic A,
  output logic B,
  output logic travado,
  output logic piscar
);

  localparam int unsigned BW = $clog2(BLINK_CYCLES) + 1;

  logic          w_prox_p;
  logic          w_conf_p;
  estado_t       r_estado;
  estado_t       w_estado_prox;
  logic [1:0]    r_modo;
  logic [1:0]    w_modo_prox;
  logic          r_travado;
  logic          r_piscar;
  logic          w_piscar_prox;
  logic [BW-1:0] r_blink_cnt;
  logic [BW-1:0] w_blink_prox;

  debounce_botao #(.DEB_CYCLES(DEB_CYCLES)) u_deb_prox (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (btn_prox_n),
    .pulso (w_prox_p)
  );

  debounce_botao #(.DEB_CYCLES(DEB_CYCLES)) u_deb_conf (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (btn_conf_n),
    .pulso (w_conf_p)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado <= SELECAO;
    end else begin
      r_estado <= w_estado_prox;
    end
  end

  // Next state; confirm has priority over next within SELECAO
  always_comb begin
    w_estado_prox = r_estado;
    case (r_estado)
      SELECAO:    if (w_conf_p) w_estado_prox = CONFIRMADO;
      CONFIRMADO: if (fim_jogo) w_estado_prox = SELECAO;
      default:    w_estado_prox = SELECAO;
    endcase
  end

  // Next output values; blink is held steady on both sides of a lock so a
  // freshly unlocked display starts a full half-period lit
  always_comb begin
    w_modo_prox   = r_modo;
    w_piscar_prox = r_piscar;
    w_blink_prox  = r_blink_cnt;
    if (r_estado == CONFIRMADO || w_estado_prox == CONFIRMADO) begin
      w_piscar_prox = 1'b1;
      w_blink_prox  = '0;
    end else if (w_prox_p) begin
      w_modo_prox   = proximo_modo(r_modo);
      w_piscar_prox = 1'b1;
      w_blink_prox  = '0;
    end else if (r_blink_cnt == BW'(BLINK_CYCLES - 1)) begin
      w_piscar_prox = ~r_piscar;
      w_blink_prox  = '0;
    end else begin
      w_blink_prox  = r_blink_cnt + BW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_modo      <= MODO_0;
      r_travado   <= 1'b0;
      r_piscar    <= 1'b1;
      r_blink_cnt <= '0;
    end else begin
      r_modo      <= w_modo_prox;
      r_travado   <= (w_estado_prox == CONFIRMADO);
      r_piscar    <= w_piscar_prox;
      r_blink_cnt <= w_blink_prox;
    end
  end

  assign A       = r_modo[1];
  assign B       = r_modo[0];
  assign travado = r_travado;
  assign piscar  = r_piscar;

endmodule

// File: tb/tb_sel_modo_de_jogo.sv
// Directed bench for sel_modo_de_jogo with DEB_CYCLES=4, BLINK_CYCLES=8.
module tb_sel_modo_de_jogo;

  logic clk;
  logic rst_n;
  logic btn_prox_n;
  logic btn_conf_n;
  logic fim_jogo;
  logic A;
  logic B;
  logic travado;
  logic piscar;

  int n_vec;
  int n_err;

  sel_modo_de_jogo #(.DEB_CYCLES(4), .BLINK_CYCLES(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_prox_n (btn_prox_n),
    .btn_conf_n (btn_conf_n),
    .fim_jogo   (fim_jogo),
    .A          (A),
    .B          (B),
    .travado    (travado),
    .piscar     (piscar)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic exp_p;
    rst_n = 1'b0; btn_prox_n = 1'b1; btn_conf_n = 1'b1; fim_jogo = 1'b0;
    step(3);
    n_vec++; if ({A, B} !== 2'b00) begin n_err++; $display("FAIL reset_ab got %b exp 00", {A, B}); end
    n_vec++; if (travado !== 1'b0) begin n_err++; $display("FAIL reset_travado got %b exp 0", travado); end
    n_vec++; if (piscar !== 1'b1) begin n_err++; $display("FAIL reset_piscar got %b exp 1", piscar); end
    rst_n = 1'b1;
    exp_p = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      if (k % 8 == 0) exp_p = ~exp_p;
      n_vec++; if ({A, B} !== 2'b00) begin n_err++; $display("FAIL idle_ab cyc %0d got %b exp 00", k, {A, B}); end
      n_vec++; if (piscar !== exp_p) begin n_err++; $display("FAIL idle_piscar cyc %0d got %b exp %b", k, piscar, exp_p); end
    end
  endtask

  task automatic test_clean_presses();
    logic [1:0] exp_ab;
    exp_ab = 2'b00;
    for (int i = 0; i < 4; i++) begin
      btn_prox_n = 1'b0;
      step(7);
      n_vec++; if ({A, B} !== exp_ab) begin n_err++; $display("FAIL press%0d_early got %b exp %b", i, {A, B}, exp_ab); end
      exp_ab = exp_ab + 2'd1;
      step(1);
      n_vec++; if ({A, B} !== exp_ab) begin n_err++; $display("FAIL press%0d_ab got %b exp %b", i, {A, B}, exp_ab); end
      n_vec++; if (piscar !== 1'b1) begin n_err++; $display("FAIL press%0d_piscar got %b exp 1", i, piscar); end
      step(4);
      btn_prox_n = 1'b1;
      step(12);
      n_vec++; if ({A, B} !== exp_ab) begin n_err++; $display("FAIL press%0d_release got %b exp %b", i, {A, B}, exp_ab); end
    end
  endtask

  task automatic test_bounce();
    btn_prox_n = 1'b0; step(3);
    btn_prox_n = 1'b1; step(1);
    btn_prox_n = 1'b0; step(3);
    btn_prox_n = 1'b1; step(12);
    n_vec++; if ({A, B} !== 2'b00) begin n_err++; $display("FAIL bounce_ab got %b exp 00", {A, B}); end
    btn_prox_n = 1'b0; step(50);
    n_vec++; if ({A, B} !== 2'b01) begin n_err++; $display("FAIL hold_ab got %b exp 01", {A, B}); end
    btn_prox_n = 1'b1; step(12);
    n_vec++; if ({A, B} !== 2'b01) begin n_err++; $display("FAIL hold_release_ab got %b exp 01", {A, B}); end
  endtask

  task automatic test_lock();
    btn_conf_n = 1'b0;
    step(7);
    n_vec++; if (travado !== 1'b0) begin n_err++; $display("FAIL conf_early got %b exp 0", travado); end
    step(1);
    n_vec++; if (travado !== 1'b1) begin n_err++; $display("FAIL conf_travado got %b exp 1", travado); end
    n_vec++; if (piscar !== 1'b1) begin n_err++; $display("FAIL conf_piscar got %b exp 1", piscar); end
    step(4);
    btn_conf_n = 1'b1;
    step(12);
    for (int i = 0; i < 3; i++) begin
      btn_prox_n = 1'b0; step(12);
      btn_prox_n = 1'b1; step(12);
    end
    n_vec++; if ({A, B} !== 2'b01) begin n_err++; $display("FAIL locked_ab got %b exp 01", {A, B}); end
    n_vec++; if (travado !== 1'b1) begin n_err++; $display("FAIL locked_travado got %b exp 1", travado); end
    n_vec++; if (piscar !== 1'b1) begin n_err++; $display("FAIL locked_piscar got %b exp 1", piscar); end
    fim_jogo = 1'b1; step(1); fim_jogo = 1'b0;
    n_vec++; if (travado !== 1'b0) begin n_err++; $display("FAIL unlock_travado got %b exp 0", travado); end
    n_vec++; if ({A, B} !== 2'b01) begin n_err++; $display("FAIL unlock_ab got %b exp 01", {A, B}); end
    step(7);
    n_vec++; if (piscar !== 1'b1) begin n_err++; $display("FAIL resume_piscar_hi got %b exp 1", piscar); end
    step(1);
    n_vec++; if (piscar !== 1'b0) begin n_err++; $display("FAIL resume_piscar_lo got %b exp 0", piscar); end
    fim_jogo = 1'b1; step(1); fim_jogo = 1'b0;
    n_vec++; if ({travado, A, B} !== 3'b001) begin n_err++; $display("FAIL fim_in_sel got %b exp 001", {travado, A, B}); end
  endtask

  task automatic test_simultaneous();
    btn_prox_n = 1'b0; step(12);
    btn_prox_n = 1'b1; step(12);
    n_vec++; if ({A, B} !== 2'b10) begin n_err++; $display("FAIL pre_sim_ab got %b exp 10", {A, B}); end
    btn_prox_n = 1'b0; btn_conf_n = 1'b0;
    step(7);
    n_vec++; if ({travado, A, B} !== 3'b010) begin n_err++; $display("FAIL sim_early got %b exp 010", {travado, A, B}); end
    step(1);
    n_vec++; if ({travado, A, B} !== 3'b110) begin n_err++; $display("FAIL sim_lock got %b exp 110", {travado, A, B}); end
    step(4);
    btn_prox_n = 1'b1; btn_conf_n = 1'b1;
    step(12);
    n_vec++; if ({travado, A, B} !== 3'b110) begin n_err++; $display("FAIL sim_release got %b exp 110", {travado, A, B}); end
    fim_jogo = 1'b1; step(1); fim_jogo = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    btn_prox_n = 1'b0;
    step(3);
    #1 rst_n = 1'b0;
    #2;
    n_vec++; if ({travado, piscar, A, B} !== 4'b0100) begin n_err++; $display("FAIL rst_deb got %b exp 0100", {travado, piscar, A, B}); end
    btn_prox_n = 1'b1;
    step(2);
    rst_n = 1'b1;
    step(20);
    n_vec++; if ({travado, A, B} !== 3'b000) begin n_err++; $display("FAIL rst_deb_after got %b exp 000", {travado, A, B}); end
    btn_prox_n = 1'b0; step(12); btn_prox_n = 1'b1; step(12);
    btn_conf_n = 1'b0; step(12); btn_conf_n = 1'b1; step(12);
    n_vec++; if ({travado, A, B} !== 3'b101) begin n_err++; $display("FAIL pre_rst_lock got %b exp 101", {travado, A, B}); end
    #1 rst_n = 1'b0;
    #2;
    n_vec++; if ({travado, piscar, A, B} !== 4'b0100) begin n_err++; $display("FAIL rst_lock got %b exp 0100", {travado, piscar, A, B}); end
    step(2);
    rst_n = 1'b1;
    step(20);
    n_vec++; if ({travado, A, B} !== 3'b000) begin n_err++; $display("FAIL rst_lock_after got %b exp 000", {travado, A, B}); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_clean_presses();
    test_bounce();
    test_lock();
    test_simultaneous();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
